memory_stage: RTL and testbench

- MEM stage of the five-stage pipelined processor. Sits between execute and write_back.
- Accepts one EX/MEM instruction per cycle, performs DLX load/store accesses on a request/ack data-memory port, and produces the registered MEM/WB bundle that write_back consumes.
- Back-pressures execute while a memory access is outstanding.
- On the halt opcode it passes the instruction downstream, then freezes.

---
 rtl/dlx_pkg.sv | 50 +++++
 rtl/memory_stage_if.sv | 54 +++++
 rtl/load_store_align.sv | 64 ++++++
 rtl/memory_stage.sv | 179 +++++++++++++++++
 tb/tb_memory_stage.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions for the MEM stage: opcodes, load/store classing and the MEM/WB bundle.
package dlx_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned BE_W   = 4;

    localparam logic [OPC_W-1:0] OP_LB   = 6'h20;
    localparam logic [OPC_W-1:0] OP_LH   = 6'h21;
    localparam logic [OPC_W-1:0] OP_LW   = 6'h23;
    localparam logic [OPC_W-1:0] OP_LBU  = 6'h24;
    localparam logic [OPC_W-1:0] OP_LHU  = 6'h25;
    localparam logic [OPC_W-1:0] OP_SB   = 6'h28;
    localparam logic [OPC_W-1:0] OP_SH   = 6'h29;
    localparam logic [OPC_W-1:0] OP_SW   = 6'h2B;
    localparam logic [OPC_W-1:0] OP_TRAP = 6'h11;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_LOAD,
        CLS_STORE
    } ls_class_e;

    function automatic ls_class_e ls_class(input logic [OPC_W-1:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return CLS_LOAD;
            OP_SB, OP_SH, OP_SW:                 return CLS_STORE;
            default:                             return CLS_NONE;
        endcase
    endfunction

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [OPC_W-1:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            OP_LW, OP_SW:         return (addr_lo != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

    typedef struct packed {
        logic              valid;
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic [DATA_W-1:0] data;
    } mem_wb_t;

endpackage

// File: rtl/memory_stage_if.sv
// EX/MEM input, data-memory port and MEM/WB output of the MEM stage.
// wb_exc exists only when MEMORY_STAGE_ALIGN_CHECK_EN is defined.
interface memory_stage_if import dlx_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [OPC_W-1:0]      in_opcode;
    logic [DATA_W-1:0]     in_alu_result;
    logic [DATA_W-1:0]     in_store_data;
    logic [REG_W-1:0]      in_rd;
    logic                  in_reg_write;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BE_W-1:0]       mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  wb_valid;
    logic [OPC_W-1:0]      wb_opcode;
    logic [REG_W-1:0]      wb_rd;
    logic                  wb_reg_write;
    logic [DATA_W-1:0]     wb_data;
    logic                  halted;
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
    logic                  wb_exc;
`endif

    // Stage side.
    modport master (
        input  in_valid, in_opcode, in_alu_result, in_store_data, in_rd, in_reg_write,
        input  mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_opcode, wb_rd, wb_reg_write, wb_data, halted
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
        , output wb_exc
`endif
    );

    // Execute / memory / write-back side.
    modport slave (
        output in_valid, in_opcode, in_alu_result, in_store_data, in_rd, in_reg_write,
        output mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_opcode, wb_rd, wb_reg_write, wb_data, halted
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
        , input wb_exc
`endif
    );

endinterface

// File: rtl/load_store_align.sv
// Big-endian byte-lane steering: store byte enables and replicated data, load lane extract/extend.
module load_store_align import dlx_pkg::*; (
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [BE_W-1:0]   o_be_c,
    output logic [DATA_W-1:0] o_wdata_c,
    output logic [DATA_W-1:0] o_load_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane 0 is the most significant byte.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
    end

    always_comb begin
        o_be_c        = '0;
        o_wdata_c     = '0;
        o_load_data_c = i_rdata;
        case (i_opcode)
            OP_LB: begin
                o_be_c        = 4'b1111;
                o_load_data_c = {{24{w_byte[7]}}, w_byte};
            end
            OP_LBU: begin
                o_be_c        = 4'b1111;
                o_load_data_c = {24'h0, w_byte};
            end
            OP_LH: begin
                o_be_c        = 4'b1111;
                o_load_data_c = {{16{w_half[15]}}, w_half};
            end
            OP_LHU: begin
                o_be_c        = 4'b1111;
                o_load_data_c = {16'h0, w_half};
            end
            OP_LW: o_be_c = 4'b1111;
            OP_SB: begin
                o_be_c    = 4'b1000 >> i_addr_lo;
                o_wdata_c = {4{i_store_data[7:0]}};
            end
            OP_SH: begin
                o_be_c    = i_addr_lo[1] ? 4'b0011 : 4'b1100;
                o_wdata_c = {2{i_store_data[15:0]}};
            end
            OP_SW: begin
                o_be_c    = 4'b1111;
                o_wdata_c = i_store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// DLX MEM stage: req/ack data-memory access, registered MEM/WB bundle, freeze on HALT_OPCODE.
// Optional misalignment exceptions: MEMORY_STAGE_ALIGN_CHECK_EN.
module memory_stage import dlx_pkg::*; #(
    parameter int unsigned      ADDR_WIDTH  = 32,
    parameter logic [OPC_W-1:0] HALT_OPCODE = 6'h11
) (
    input  logic clk,
    input  logic reset,
    memory_stage_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_HALTED
    } state_e;

    state_e                r_state, w_state_nxt;
    mem_wb_t               r_wb, w_wb_nxt;
    logic                  r_in_ready, w_in_ready_nxt;
    logic                  r_halted, w_halted_nxt;
    logic                  r_mem_req, w_mem_req_nxt;
    logic                  r_mem_we, w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [BE_W-1:0]       r_mem_be, w_mem_be_nxt;
    logic [DATA_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;
    logic [OPC_W-1:0]      r_opcode, w_opcode_nxt;
    logic [REG_W-1:0]      r_rd, w_rd_nxt;
    logic                  r_reg_write, w_reg_write_nxt;
    logic [DATA_W-1:0]     r_alu, w_alu_nxt;
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
    logic                  r_wb_exc, w_wb_exc_nxt;
`endif

    logic                  w_accept;
    logic                  w_in_wait;
    logic [OPC_W-1:0]      w_al_opcode;
    logic [1:0]            w_al_addr_lo;
    logic [BE_W-1:0]       w_be;
    logic [DATA_W-1:0]     w_wdata;
    logic [DATA_W-1:0]     w_load_data;

    assign w_accept     = r_in_ready & bus.in_valid;
    assign w_in_wait    = (r_state == ST_WAIT_ACK);
    // Aligner serves the incoming store while idle and the pending load while waiting.
    assign w_al_opcode  = w_in_wait ? r_opcode : bus.in_opcode;
    assign w_al_addr_lo = w_in_wait ? r_alu[1:0] : bus.in_alu_result[1:0];

    load_store_align u_align (
        .i_opcode      (w_al_opcode),
        .i_addr_lo     (w_al_addr_lo),
        .i_store_data  (bus.in_store_data),
        .i_rdata       (bus.mem_rdata),
        .o_be_c        (w_be),
        .o_wdata_c     (w_wdata),
        .o_load_data_c (w_load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wb_nxt        = '0;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_be_nxt    = r_mem_be;
        w_mem_wdata_nxt = r_mem_wdata;
        w_opcode_nxt    = r_opcode;
        w_rd_nxt        = r_rd;
        w_reg_write_nxt = r_reg_write;
        w_alu_nxt       = r_alu;
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
        w_wb_exc_nxt    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: if (w_accept) begin
                w_wb_nxt.opcode = bus.in_opcode;
                w_wb_nxt.rd     = bus.in_rd;
                w_wb_nxt.data   = bus.in_alu_result;
                if (bus.in_opcode == HALT_OPCODE) begin
                    w_wb_nxt.valid = 1'b1;
                    w_state_nxt    = ST_HALTED;
                end else if (ls_class(bus.in_opcode) == CLS_NONE) begin
                    w_wb_nxt.valid     = 1'b1;
                    w_wb_nxt.reg_write = bus.in_reg_write;
                end
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
                else if (is_misaligned(bus.in_opcode, bus.in_alu_result[1:0])) begin
                    w_wb_nxt.valid = 1'b1;
                    w_wb_exc_nxt   = 1'b1;
                end
`endif
                else begin
                    w_wb_nxt        = '0;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = (ls_class(bus.in_opcode) == CLS_STORE);
                    w_mem_addr_nxt  = {bus.in_alu_result[ADDR_WIDTH-1:2], 2'b00};
                    w_mem_be_nxt    = w_be;
                    w_mem_wdata_nxt = w_wdata;
                    w_opcode_nxt    = bus.in_opcode;
                    w_rd_nxt        = bus.in_rd;
                    w_reg_write_nxt = bus.in_reg_write & (ls_class(bus.in_opcode) != CLS_STORE);
                    w_alu_nxt       = bus.in_alu_result;
                    w_state_nxt     = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: if (bus.mem_ack) begin
                w_wb_nxt.valid     = 1'b1;
                w_wb_nxt.opcode    = r_opcode;
                w_wb_nxt.rd        = r_rd;
                w_wb_nxt.reg_write = r_reg_write;
                w_wb_nxt.data      = (ls_class(r_opcode) == CLS_STORE) ? r_alu : w_load_data;
                w_mem_req_nxt      = 1'b0;
                w_state_nxt        = ST_IDLE;
            end
            default: ;
        endcase
        w_in_ready_nxt = (w_state_nxt == ST_IDLE);
        w_halted_nxt   = (w_state_nxt == ST_HALTED);
    end

    // in_ready is registered, so it rises on the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb        <= '0;
            r_in_ready  <= 1'b0;
            r_halted    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_alu       <= '0;
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
            r_wb_exc    <= 1'b0;
`endif
        end else begin
            r_wb        <= w_wb_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_halted    <= w_halted_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_opcode    <= w_opcode_nxt;
            r_rd        <= w_rd_nxt;
            r_reg_write <= w_reg_write_nxt;
            r_alu       <= w_alu_nxt;
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
            r_wb_exc    <= w_wb_exc_nxt;
`endif
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.halted       = r_halted;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_be       = r_mem_be;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.wb_valid     = r_wb.valid;
    assign bus.wb_opcode    = r_wb.opcode;
    assign bus.wb_rd        = r_wb.rd;
    assign bus.wb_reg_write = r_wb.reg_write;
    assign bus.wb_data      = r_wb.data;
`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
    assign bus.wb_exc       = r_wb_exc;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, random ops vs. a lane-arithmetic model,
// and hand sequences for back-to-back ALU ops, reset during an access and halt.
module tb_memory_stage;
    import dlx_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memory_stage_if #(.ADDR_WIDTH(32)) bus ();

    memory_stage #(.ADDR_WIDTH(32), .HALT_OPCODE(6'h11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.in_valid      = 1'b0;
        bus.in_opcode     = '0;
        bus.in_alu_result = '0;
        bus.in_store_data = '0;
        bus.in_rd         = '0;
        bus.in_reg_write  = 1'b0;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (bus.in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic drive_op(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                            input logic [4:0] rd, input logic rw);
        bus.in_valid      = 1'b1;
        bus.in_opcode     = op;
        bus.in_alu_result = alu;
        bus.in_store_data = sd;
        bus.in_rd         = rd;
        bus.in_reg_write  = rw;
    endtask

    // Reference model: lane 0 is the top byte; sign extension by subtracting 2^n.
    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rdata);
        int unsigned lane = a % 4;
        logic [31:0] v = rdata;
        if (op == OP_LB || op == OP_LBU) begin
            v = (rdata >> (8 * (3 - lane))) & 32'hFF;
            if (op == OP_LB && v >= 128) v = v - 32'd256;
        end else if (op == OP_LH || op == OP_LHU) begin
            v = (rdata >> ((lane < 2) ? 16 : 0)) & 32'hFFFF;
            if (op == OP_LH && v >= 32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
        int unsigned lane = a % 4;
        if (op == OP_SB) return 4'(1 << (3 - lane));
        if (op == OP_SH) return (lane < 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] sd);
        if (op == OP_SB) return (sd & 32'hFF) * 32'h0101_0101;
        if (op == OP_SH) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    task automatic run_alu(input logic [5:0] op, input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        wait_ready("alu");
        drive_op(op, alu, 32'h0, rd, rw);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("alu_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("alu_wb_data", bus.wb_data, alu);
        chk("alu_wb_rw", 32'(bus.wb_reg_write), 32'(rw));
        chk("alu_wb_rd", 32'(bus.wb_rd), 32'(rd));
        chk("alu_mem_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        chk("alu_wb_pulse", 32'(bus.wb_valid), 32'd0);
    endtask

    task automatic run_mem(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] rd, input logic [31:0] rdata, input int nwait,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_wb, input logic exp_rw);
        logic is_st = (op == OP_SB || op == OP_SH || op == OP_SW);
        wait_ready("mem");
        drive_op(op, alu, sd, rd, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int w = 1; w <= nwait; w++) begin
            chk("mem_req", 32'(bus.mem_req), 32'd1);
            chk("mem_addr", bus.mem_addr, alu & 32'hFFFF_FFFC);
            chk("mem_be", 32'(bus.mem_be), 32'(exp_be));
            chk("mem_we", 32'(bus.mem_we), 32'(is_st));
            if (is_st) chk("mem_wdata", bus.mem_wdata, exp_wdata);
            chk("mem_in_ready", 32'(bus.in_ready), 32'd0);
            chk("mem_wb_idle", 32'(bus.wb_valid), 32'd0);
            bus.mem_ack   = (w == nwait);
            bus.mem_rdata = (w == nwait) ? rdata : $urandom;
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        chk("mem_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("mem_wb_data", bus.wb_data, exp_wb);
        chk("mem_wb_rw", 32'(bus.wb_reg_write), 32'(exp_rw));
        chk("mem_wb_op", 32'(bus.wb_opcode), 32'(op));
        chk("mem_wb_rd", 32'(bus.wb_rd), 32'(rd));
        chk("mem_req_drop", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        chk("mem_wb_pulse", 32'(bus.wb_valid), 32'd0);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          nwait;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] wb;
        logic        rw;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [5:0]  op;
        logic [31:0] alu, sd, rdata;
        logic [4:0]  rd;
        logic        rw;
        logic [5:0]  loads[5]  = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        logic [5:0]  stores[3] = '{OP_SB, OP_SH, OP_SW};

        tbl.push_back('{OP_LB,  32'h101, 32'h0,       32'h11F2_3344, 3, 4'hF, 32'h0,       32'hFFFF_FFF2, 1'b1});
        tbl.push_back('{OP_LHU, 32'h102, 32'h0,       32'hAAAA_8001, 1, 4'hF, 32'h0,       32'h0000_8001, 1'b1});
        tbl.push_back('{OP_SB,  32'h203, 32'h0000_00A5, 32'h0,       1, 4'h1, 32'hA5A5_A5A5, 32'h203,     1'b0});
        tbl.push_back('{OP_LW,  32'h300, 32'h0,       32'hDEAD_BEEF, 2, 4'hF, 32'h0,       32'hDEAD_BEEF, 1'b1});
        tbl.push_back('{OP_LH,  32'h100, 32'h0,       32'h8001_1234, 1, 4'hF, 32'h0,       32'hFFFF_8001, 1'b1});
        tbl.push_back('{OP_LBU, 32'h100, 32'h0,       32'h80FF_0000, 1, 4'hF, 32'h0,       32'h0000_0080, 1'b1});
        tbl.push_back('{OP_SH,  32'h402, 32'h1234_BEEF, 32'h0,       2, 4'h3, 32'hBEEF_BEEF, 32'h402,     1'b0});
        tbl.push_back('{OP_SW,  32'h500, 32'hCAFE_F00D, 32'h0,       1, 4'hF, 32'hCAFE_F00D, 32'h500,     1'b0});
`ifndef MEMORY_STAGE_ALIGN_CHECK_EN
        tbl.push_back('{OP_LH,  32'h103, 32'h0,       32'h1234_5678, 1, 4'hF, 32'h0,       32'h0000_5678, 1'b1});
`endif

        drive_idle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Three back-to-back ADDs.
        wait_ready("add");
        drive_op(6'h00, 32'h1234, 32'h0, 5'd3, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("add_wb_valid", 32'(bus.wb_valid), 32'd1);
            chk("add_wb_data", bus.wb_data, 32'h1234);
            chk("add_mem_req", 32'(bus.mem_req), 32'd0);
            chk("add_in_ready", 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("add_wb_end", 32'(bus.wb_valid), 32'd0);

        foreach (tbl[i])
            run_mem(tbl[i].op, tbl[i].alu, tbl[i].sd, 5'(i + 1), tbl[i].rdata, tbl[i].nwait,
                    tbl[i].be, tbl[i].wdata, tbl[i].wb, tbl[i].rw);

        for (int it = 0; it < 40; it++) begin
            alu   = $urandom;
            sd    = $urandom;
            rdata = $urandom;
            rd    = 5'($urandom_range(0, 31));
            rw    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: run_alu(6'($urandom_range(0, 15)), alu, rd, rw);
                1: begin
                    op = loads[$urandom_range(0, 4)];
                    if (op == OP_LH || op == OP_LHU) alu = alu & 32'hFFFF_FFFE;
                    if (op == OP_LW) alu = alu & 32'hFFFF_FFFC;
                    run_mem(op, alu, sd, rd, rdata, int'($urandom_range(1, 3)), 4'hF, 32'h0,
                            m_load(op, alu, rdata), 1'b1);
                end
                default: begin
                    op = stores[$urandom_range(0, 2)];
                    if (op == OP_SH) alu = alu & 32'hFFFF_FFFE;
                    if (op == OP_SW) alu = alu & 32'hFFFF_FFFC;
                    run_mem(op, alu, sd, rd, rdata, int'($urandom_range(1, 3)), m_be(op, alu),
                            m_wdata(op, sd), alu, 1'b0);
                end
            endcase
        end

`ifdef MEMORY_STAGE_ALIGN_CHECK_EN
        wait_ready("exc");
        drive_op(OP_LW, 32'h101, 32'h0, 5'd7, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("exc_mem_req", 32'(bus.mem_req), 32'd0);
        chk("exc_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("exc_flag", 32'(bus.wb_exc), 32'd1);
        chk("exc_wb_rw", 32'(bus.wb_reg_write), 32'd0);
        chk("exc_wb_data", bus.wb_data, 32'h101);
        @(negedge clk);
        chk("exc_flag_pulse", 32'(bus.wb_exc), 32'd0);
`endif

        // Reset in the middle of an access; a late ack must be ignored.
        wait_ready("rst");
        drive_op(OP_LW, 32'h600, 32'h0, 5'd9, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rst_pre_req", 32'(bus.mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_req_async", 32'(bus.mem_req), 32'd0);
        chk("rst_wb_async", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        reset         = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("rst_late_ack_wb", 32'(bus.wb_valid), 32'd0);
        chk("rst_late_ack_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        chk("rst_idle_wb", 32'(bus.wb_valid), 32'd0);
        chk("rst_idle_ready", 32'(bus.in_ready), 32'd1);
        run_alu(6'h08, 32'hBEEF_0001, 5'd4, 1'b1);

        // Halt, followed by an ADD that must never be forwarded.
        wait_ready("halt");
        drive_op(6'h11, 32'h77, 32'h0, 5'd2, 1'b1);
        @(negedge clk);
        drive_op(6'h00, 32'h9999, 32'h0, 5'd5, 1'b1);
        chk("halt_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("halt_wb_op", 32'(bus.wb_opcode), 32'h11);
        chk("halt_wb_rw", 32'(bus.wb_reg_write), 32'd0);
        chk("halt_wb_data", bus.wb_data, 32'h77);
        chk("halt_halted", 32'(bus.halted), 32'd1);
        chk("halt_in_ready", 32'(bus.in_ready), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("halt_frozen_wb", 32'(bus.wb_valid), 32'd0);
            chk("halt_frozen_flag", 32'(bus.halted), 32'd1);
            chk("halt_frozen_ready", 32'(bus.in_ready), 32'd0);
            chk("halt_frozen_req", 32'(bus.mem_req), 32'd0);
        end
        bus.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
